fscmos_tx: RTL and testbench
============================

Name: fscmos_tx

Overview:
- Transmit-side counterpart of the CMOS capture path: a DVP sensor emulator that turns an AXI4-Stream pixel source (tuser = start of frame, tlast = end of line) into CMOS-style cmos_vsync, cmos_href and cmos_data.
- Used to loop frame-buffer content back into the capture pipeline for bring-up and regression, and to drive downstream DVP consumers.
- Sensor timing is free-running once a frame starts and never stalls; the stream side is the one that absorbs back-pressure.

Parameters:
- C_DATA_WIDTH, 8, pixel width
- C_IMG_WBITS, 12, width of the line-length and h-blank counters
- C_IMG_HBITS, 12, width of the line-count and v-blank counters

Ports:
- cmos_pclk  in  1  single clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  start frames; when deasserted, the current frame completes, then the block idles
- img_width  in  C_IMG_WBITS  pixels per line, latched at frame start
- img_height  in  C_IMG_HBITS  lines per frame, latched at frame start
- hblank  in  C_IMG_WBITS  href-low cycles between lines, latched at frame start
- vblank  in  C_IMG_HBITS  vsync-low cycles between frames, latched at frame start
- s_axis_tvalid  in  1  pixel valid
- s_axis_tdata  in  C_DATA_WIDTH  pixel
- s_axis_tuser  in  1  start of frame
- s_axis_tlast  in  1  end of line
- s_axis_tready  out  1  pixel accept
- cmos_vsync  out  1  high for the whole frame (lead, lines and gaps)
- cmos_href  out  1  high during active pixels
- cmos_data  out  C_DATA_WIDTH  pixel; 0 when href is low
- underflow  out  1  sticky: pixel slot found the stream empty
- eol_err  out  1  sticky: tlast position disagrees with img_width
- frame_done  out  1  one-cycle pulse on the last active pixel of a frame

Behaviour:
- Reset: all outputs 0 (vsync, href, data, tready, flags, frame_done), FSM in IDLE, need_sof = 1.
- FSM states: IDLE, VBLANK, VLEAD, LINE, HGAP.
- IDLE: vsync = 0.
  - Exit to VBLANK when enable = 1 and img_width, img_height are both nonzero.
- VBLANK: vsync = 0 for max(vblank, 1) cycles.
  - At exit, latch img_width, img_height, hblank, vblank.
  - If enable = 0 or a latched size is 0, go to IDLE; otherwise go to VLEAD.
- VLEAD: vsync = 1, href = 0 for max(hblank, 1) cycles, then LINE.
- LINE: vsync = 1, href = 1 for exactly img_width cycles, one pixel slot per cycle.
  - At the end of a line: go to HGAP if lines remain, else VBLANK.
  - frame_done pulses with the last pixel slot of the last line.
- HGAP: vsync = 1, href = 0 for max(hblank, 1) cycles, then LINE.
- Outputs are registered. A pixel accepted in cycle n appears on cmos_data, with href high, in cycle n+1. vsync and href come from the same register stage, so they stay aligned.
- s_axis_tready:
  - In LINE with need_sof = 0: tready = 1, one beat per slot.
  - Otherwise, while need_sof = 1: tready = !s_axis_tuser. Non-SOF beats are discarded in any state; an SOF beat is held until slot 0 of line 0.
  - At slot 0 of line 0 (need_sof = 1): tready = 1. The SOF beat is consumed and need_sof clears.
- need_sof is set again on entry to VBLANK, so every frame resynchronises on tuser.
- Underflow: no beat is available for a LINE slot (tvalid = 0, or need_sof still set at slot 0). Then:
  - cmos_data = 0 for that slot, underflow is set, and the slot is consumed.
  - Timing never stretches.
  - If the SOF beat was missing at slot 0, the frame is emitted as zeros and need_sof stays set until next VBLANK.
- eol_err is set when either:
  - an accepted beat has tlast = 1 at a column other than img_width-1, or
  - it has tlast = 0 at column img_width-1.
- No realignment happens within a frame.
- Sticky flags clear only on reset.
- Simultaneous events:
  - enable falling mid-frame has no effect until VBLANK exit.
  - Size inputs changing mid-frame are ignored until the next latch.
- Counters are compared for equality with the latched value minus 1, so there is no wrap.
- Reset mid-frame: vsync and href drop in the next cycle.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, VBLANK, VLEAD, LINE, HGAP);
  - the DVP polarity constants (vsync active-high per frame, href active-high per line), shared with the capture side.
- One natural sub-module: fscmos_tx_timing, holding the FSM and counters, which outputs slot/line-start/frame-start strobes.
- The stream-consumption and output-register logic stays in fscmos_tx.

Test Plan:
- Width 4, height 2, hblank 3, vblank 5, with a continuous valid stream and tuser on the first pixel:
  - required: vsync low 5 cycles, then high 3 cycles, href high 4, low 3, high 4;
  - data equals the stream, delayed one cycle;
  - frame_done pulses once; no flags.
- Three junk beats without tuser ahead of the SOF beat -> junk is dropped during VBLANK, and line 0 pixel 0 equals the SOF data.
- tvalid dropped for 2 cycles mid-line -> those 2 slots output 0, underflow = 1, and href width is still 4.
- tlast on column 2 with width 4 -> eol_err = 1, timing unchanged.
- enable deasserted during line 0 -> the frame completes, VBLANK runs, then IDLE with vsync held low.
- Reset asserted mid-LINE -> the next cycle has vsync = href = data = 0 and tready = 0.

Source files
------------

// File: rtl/fscmos_tx_pkg.sv
// Shared definitions for the DVP transmit path: FSM state encoding and the
// sync polarities that the capture side also relies on.
package fscmos_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VBLANK = 3'd1,
        ST_VLEAD  = 3'd2,
        ST_LINE   = 3'd3,
        ST_HGAP   = 3'd4
    } state_t;

    // vsync is high for a whole frame, href is high for the active pixels of a line
    localparam logic VSYNC_ACTIVE = 1'b1;
    localparam logic HREF_ACTIVE  = 1'b1;

endpackage

// File: rtl/fscmos_tx_if.sv
// AXI4-Stream pixel bus feeding the DVP transmitter (tuser = start of frame,
// tlast = end of line).
//
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high. While tvalid is high and tready is low the source holds
// tdata/tuser/tlast stable. tready may depend combinationally on tuser.
interface fscmos_tx_if #(parameter int C_DATA_WIDTH = 8);

    logic                    s_axis_tvalid;
    logic [C_DATA_WIDTH-1:0] s_axis_tdata;
    logic                    s_axis_tuser;
    logic                    s_axis_tlast;
    logic                    s_axis_tready;

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tuser, s_axis_tlast,
        input  s_axis_tready
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tuser, s_axis_tlast,
        output s_axis_tready
    );

endinterface

// File: rtl/fscmos_tx_timing.sv
// Free-running DVP frame timing: the FSM plus column/line counters. It never
// waits on the stream; it only reports which cycle is which slot.
module fscmos_tx_timing
    import fscmos_tx_pkg::*;
#(
    parameter int C_IMG_WBITS = 12,
    parameter int C_IMG_HBITS = 12
) (
    input  logic                   cmos_pclk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [C_IMG_WBITS-1:0] img_width,
    input  logic [C_IMG_HBITS-1:0] img_height,
    input  logic [C_IMG_WBITS-1:0] hblank,
    input  logic [C_IMG_HBITS-1:0] vblank,
    output state_t                 state,
    output logic                   frame_active,
    output logic                   line_slot,
    output logic                   line_start,
    output logic                   first_line,
    output logic                   col_last,
    output logic                   frame_end,
    output logic                   vblank_entry
);

    // h_cnt counts columns and blanking cycles; v_cnt counts lines and the
    // vblank cycles (the two never overlap in time).
    logic [C_IMG_WBITS-1:0] h_cnt, h_next;
    logic [C_IMG_HBITS-1:0] v_cnt, v_next;
    logic [C_IMG_WBITS-1:0] w_lat, hb_lat;
    logic [C_IMG_HBITS-1:0] h_lat, vb_lat;
    logic [C_IMG_WBITS-1:0] w_end, hb_end;
    logic [C_IMG_HBITS-1:0] h_end, vb_end;
    logic                   sizes_ok;
    logic                   latch_en;
    state_t                 state_next;

    // Terminal counts; a zero blanking value still gives one cycle.
    assign w_end    = w_lat - 1'b1;
    assign h_end    = h_lat - 1'b1;
    assign hb_end   = (hb_lat == '0) ? '0 : hb_lat - 1'b1;
    assign vb_end   = (vb_lat == '0) ? '0 : vb_lat - 1'b1;
    assign sizes_ok = (img_width != '0) && (img_height != '0);

    assign frame_active = (state == ST_VLEAD) || (state == ST_LINE) || (state == ST_HGAP);
    assign line_slot    = (state == ST_LINE);
    assign line_start   = line_slot && (h_cnt == '0);
    assign first_line   = (v_cnt == '0);
    assign col_last     = line_slot && (h_cnt == w_end);
    assign frame_end    = col_last && (v_cnt == h_end);

    // Next-state, counter and latch-enable decode.
    always_comb begin
        state_next   = state;
        h_next       = h_cnt;
        v_next       = v_cnt;
        latch_en     = 1'b0;
        vblank_entry = 1'b0;
        case (state)
            ST_IDLE: begin
                h_next = '0;
                v_next = '0;
                if (enable && sizes_ok) begin
                    state_next   = ST_VBLANK;
                    latch_en     = 1'b1;
                    vblank_entry = 1'b1;
                end
            end
            ST_VBLANK: begin
                if (v_cnt == vb_end) begin
                    latch_en   = 1'b1;
                    h_next     = '0;
                    v_next     = '0;
                    state_next = (enable && sizes_ok) ? ST_VLEAD : ST_IDLE;
                end else begin
                    v_next = v_cnt + 1'b1;
                end
            end
            ST_VLEAD, ST_HGAP: begin
                if (h_cnt == hb_end) begin
                    h_next     = '0;
                    state_next = ST_LINE;
                end else begin
                    h_next = h_cnt + 1'b1;
                end
            end
            ST_LINE: begin
                if (h_cnt == w_end) begin
                    h_next = '0;
                    if (v_cnt == h_end) begin
                        v_next       = '0;
                        state_next   = ST_VBLANK;
                        vblank_entry = 1'b1;
                    end else begin
                        v_next     = v_cnt + 1'b1;
                        state_next = ST_HGAP;
                    end
                end else begin
                    h_next = h_cnt + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, counters and frame geometry registers.
    always_ff @(posedge cmos_pclk) begin
        if (reset) begin
            state  <= ST_IDLE;
            h_cnt  <= '0;
            v_cnt  <= '0;
            w_lat  <= '0;
            h_lat  <= '0;
            hb_lat <= '0;
            vb_lat <= '0;
        end else begin
            state <= state_next;
            h_cnt <= h_next;
            v_cnt <= v_next;
            if (latch_en) begin
                w_lat  <= img_width;
                h_lat  <= img_height;
                hb_lat <= hblank;
                vb_lat <= vblank;
            end
        end
    end

endmodule

// File: rtl/fscmos_tx.sv
// DVP sensor emulator: drains an AXI4-Stream pixel source into registered
// cmos_vsync / cmos_href / cmos_data. Timing never stalls; missing pixels are
// sent as zero and flagged.
module fscmos_tx
    import fscmos_tx_pkg::*;
#(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_IMG_WBITS  = 12,
    parameter int C_IMG_HBITS  = 12
) (
    input  logic                    cmos_pclk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [C_IMG_WBITS-1:0]  img_width,
    input  logic [C_IMG_HBITS-1:0]  img_height,
    input  logic [C_IMG_WBITS-1:0]  hblank,
    input  logic [C_IMG_HBITS-1:0]  vblank,
    fscmos_tx_if.slave              axis,
    output logic                    cmos_vsync,
    output logic                    cmos_href,
    output logic [C_DATA_WIDTH-1:0] cmos_data,
    output logic                    underflow,
    output logic                    eol_err,
    output logic                    frame_done,
    output state_t                  fsm_state
);

    logic   frame_active, line_slot, line_start, first_line;
    logic   col_last, frame_end, vblank_entry;
    logic   sof_slot;
    logic   need_sof;
    logic   tready;
    logic   pix_take;
    state_t state;

    fscmos_tx_timing #(
        .C_IMG_WBITS (C_IMG_WBITS),
        .C_IMG_HBITS (C_IMG_HBITS)
    ) u_timing (
        .cmos_pclk    (cmos_pclk),
        .reset        (reset),
        .enable       (enable),
        .img_width    (img_width),
        .img_height   (img_height),
        .hblank       (hblank),
        .vblank       (vblank),
        .state        (state),
        .frame_active (frame_active),
        .line_slot    (line_slot),
        .line_start   (line_start),
        .first_line   (first_line),
        .col_last     (col_last),
        .frame_end    (frame_end),
        .vblank_entry (vblank_entry)
    );

    assign fsm_state = state;
    assign sof_slot  = line_start && first_line;

    // Accept policy: while hunting for SOF, drop non-SOF beats and hold the SOF
    // beat until slot 0 of line 0; once synced, take exactly one beat per slot.
    always_comb begin
        tready = 1'b0;
        if (!reset) begin
            if (need_sof) begin
                tready = sof_slot ? 1'b1 : !axis.s_axis_tuser;
            end else begin
                tready = line_slot;
            end
        end
    end

    assign axis.s_axis_tready = tready;

    // A slot gets a real pixel only when synced, or when the SOF beat lands on slot 0.
    assign pix_take = line_slot && axis.s_axis_tvalid &&
                      (!need_sof || (sof_slot && axis.s_axis_tuser));

    // Output stage, SOF tracking and sticky error flags.
    always_ff @(posedge cmos_pclk) begin
        if (reset) begin
            cmos_vsync <= 1'b0;
            cmos_href  <= 1'b0;
            cmos_data  <= '0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
            eol_err    <= 1'b0;
            need_sof   <= 1'b1;
        end else begin
            cmos_vsync <= frame_active ? VSYNC_ACTIVE : !VSYNC_ACTIVE;
            cmos_href  <= line_slot ? HREF_ACTIVE : !HREF_ACTIVE;
            cmos_data  <= pix_take ? axis.s_axis_tdata : '0;
            frame_done <= frame_end;
            if (line_slot && !pix_take) begin
                underflow <= 1'b1;
            end
            if (pix_take && (axis.s_axis_tlast != col_last)) begin
                eol_err <= 1'b1;
            end
            if (vblank_entry) begin
                need_sof <= 1'b1;
            end else if (pix_take && need_sof) begin
                need_sof <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fscmos_tx.sv
// Directed bench for fscmos_tx: frame shape, SOF resync, underflow, tlast
// errors, enable stop and mid-frame reset.
module tb_fscmos_tx;
    import fscmos_tx_pkg::*;

    localparam int DW = 8;
    localparam int WB = 12;
    localparam int HB = 12;

    logic          cmos_pclk = 1'b0;
    logic          reset;
    logic          enable;
    logic [WB-1:0] img_width, hblank;
    logic [HB-1:0] img_height, vblank;
    logic          cmos_vsync, cmos_href, underflow, eol_err, frame_done;
    logic [DW-1:0] cmos_data;
    state_t        fsm_state;

    fscmos_tx_if #(.C_DATA_WIDTH(DW)) axis ();

    fscmos_tx #(
        .C_DATA_WIDTH (DW),
        .C_IMG_WBITS  (WB),
        .C_IMG_HBITS  (HB)
    ) dut (
        .cmos_pclk  (cmos_pclk),
        .reset      (reset),
        .enable     (enable),
        .img_width  (img_width),
        .img_height (img_height),
        .hblank     (hblank),
        .vblank     (vblank),
        .axis       (axis),
        .cmos_vsync (cmos_vsync),
        .cmos_href  (cmos_href),
        .cmos_data  (cmos_data),
        .underflow  (underflow),
        .eol_err    (eol_err),
        .frame_done (frame_done),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 cmos_pclk = ~cmos_pclk;

    // ---------------- stream source ----------------
    typedef struct packed {
        logic          gap;
        logic          user;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t src_q[$];

    // A gap entry holds tvalid low for exactly one cycle.
    always @(posedge cmos_pclk) begin
        if (src_q.size() > 0) begin
            if (src_q[0].gap || (axis.s_axis_tvalid && axis.s_axis_tready)) begin
                void'(src_q.pop_front());
            end
        end
        #1;
        if (src_q.size() > 0 && !src_q[0].gap) begin
            axis.s_axis_tvalid = 1'b1;
            axis.s_axis_tdata  = src_q[0].data;
            axis.s_axis_tuser  = src_q[0].user;
            axis.s_axis_tlast  = src_q[0].last;
        end else begin
            axis.s_axis_tvalid = 1'b0;
            axis.s_axis_tdata  = '0;
            axis.s_axis_tuser  = 1'b0;
            axis.s_axis_tlast  = 1'b0;
        end
    end

    task automatic push_beat(input logic [DW-1:0] d, input logic u, input logic l);
        beat_t b;
        b = '{gap: 1'b0, user: u, last: l, data: d};
        src_q.push_back(b);
    endtask

    task automatic push_gap();
        beat_t b;
        b = '{gap: 1'b1, user: 1'b0, last: 1'b0, data: '0};
        src_q.push_back(b);
    endtask

    // ---------------- bookkeeping / capture ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic          tr_vs[64];
    logic          tr_hr[64];
    logic          tr_fd[64];
    logic [DW-1:0] tr_d[64];
    logic [DW-1:0] exp_pix[16];

    task automatic tick();
        @(posedge cmos_pclk);
        #2;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        src_q.delete();
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic set_geometry();
        img_width  = 12'd4;
        img_height = 12'd2;
        hblank     = 12'd3;
        vblank     = 12'd5;
    endtask

    // Waits (bounded) for vsync to rise, then records n cycles of outputs;
    // enable is dropped right after trace entry drop_en_at.
    task automatic capture(input int n, input int drop_en_at);
        int budget;
        budget = 0;
        while (cmos_vsync !== 1'b1 && budget < 100) begin
            tick();
            budget++;
        end
        n_checks++;
        if (cmos_vsync !== 1'b1) begin
            $display("FAIL capture_start: vsync=%b after %0d cycles, required 1", cmos_vsync, budget);
        end else begin
            n_pass++;
            for (int i = 0; i < n; i++) begin
                if (i > 0) tick();
                tr_vs[i] = cmos_vsync;
                tr_hr[i] = cmos_href;
                tr_fd[i] = frame_done;
                tr_d[i]  = cmos_data;
                if (i == drop_en_at) enable = 1'b0;
            end
        end
    endtask

    // Frame-relative trace index -> pixel slot for width 4, height 2, hblank 3.
    function automatic int slot_of(input int k);
        if (k >= 3 && k <= 6) return k - 3;
        if (k >= 10 && k <= 13) return k - 6;
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        set_geometry();
        tick();
        tick();
        n_checks++;
        if ({cmos_vsync, cmos_href, cmos_data, axis.s_axis_tready, underflow, eol_err, frame_done} !== '0)
            $display("FAIL reset_outputs: got vs=%b href=%b data=%h tready=%b uf=%b eol=%b fd=%b, required all 0",
                     cmos_vsync, cmos_href, cmos_data, axis.s_axis_tready, underflow, eol_err, frame_done);
        else n_pass++;
        n_checks++;
        if (fsm_state !== ST_IDLE)
            $display("FAIL reset_state: got %0d, required %0d", fsm_state, ST_IDLE);
        else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    // Two back-to-back frames: lead 3, line 4, gap 3, line 4, vblank 5.
    task automatic test_basic_frame();
        logic [DW+2:0] exp_v, act_v;
        int fk, s;
        do_reset();
        set_geometry();
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 8; p++) begin
                exp_pix[f*8 + p] = (f == 0) ? (8'h10 + 8'(p)) : (8'hA0 + 8'(p * 3));
                push_beat(exp_pix[f*8 + p], p == 0, (p % 4) == 3);
            end
        end
        enable = 1'b1;
        capture(33, 22);
        for (int i = 0; i < 33; i++) begin
            fk = i % 19;
            s  = slot_of(fk);
            exp_v = {fk < 14, s >= 0, fk == 13, (s >= 0) ? exp_pix[(i / 19) * 8 + s] : 8'h00};
            act_v = {tr_vs[i], tr_hr[i], tr_fd[i], tr_d[i]};
            n_checks++;
            if (act_v !== exp_v)
                $display("FAIL basic_trace[%0d]: got {vs,href,fd,data}=%h, required %h", i, act_v, exp_v);
            else n_pass++;
        end
        n_checks++;
        if ({underflow, eol_err} !== 2'b00)
            $display("FAIL basic_flags: got uf=%b eol=%b, required 0 0", underflow, eol_err);
        else n_pass++;
    endtask

    task automatic test_junk_sof();
        logic [DW+2:0] exp_v, act_v;
        int s;
        do_reset();
        set_geometry();
        push_beat(8'hEE, 1'b0, 1'b0);
        push_beat(8'hDD, 1'b0, 1'b1);
        push_beat(8'hCC, 1'b0, 1'b0);
        for (int p = 0; p < 8; p++) begin
            exp_pix[p] = 8'h31 + 8'(p * 7);
            push_beat(exp_pix[p], p == 0, (p % 4) == 3);
        end
        enable = 1'b1;
        capture(19, 3);
        for (int i = 0; i < 19; i++) begin
            s = slot_of(i);
            exp_v = {i < 14, s >= 0, i == 13, (s >= 0) ? exp_pix[s] : 8'h00};
            act_v = {tr_vs[i], tr_hr[i], tr_fd[i], tr_d[i]};
            n_checks++;
            if (act_v !== exp_v)
                $display("FAIL junk_trace[%0d]: got {vs,href,fd,data}=%h, required %h", i, act_v, exp_v);
            else n_pass++;
        end
        n_checks++;
        if ({underflow, eol_err} !== 2'b00)
            $display("FAIL junk_flags: got uf=%b eol=%b, required 0 0", underflow, eol_err);
        else n_pass++;
    endtask

    // tvalid low for line 0 slots 1 and 2: those output zero, timing unchanged.
    task automatic test_underflow();
        logic [DW+2:0] exp_v, act_v;
        int s;
        do_reset();
        set_geometry();
        push_beat(8'h51, 1'b1, 1'b0);
        push_gap();
        push_gap();
        push_beat(8'h52, 1'b0, 1'b1);
        push_beat(8'h53, 1'b0, 1'b0);
        push_beat(8'h54, 1'b0, 1'b0);
        push_beat(8'h55, 1'b0, 1'b0);
        push_beat(8'h56, 1'b0, 1'b1);
        exp_pix[0] = 8'h51; exp_pix[1] = 8'h00; exp_pix[2] = 8'h00; exp_pix[3] = 8'h52;
        exp_pix[4] = 8'h53; exp_pix[5] = 8'h54; exp_pix[6] = 8'h55; exp_pix[7] = 8'h56;
        enable = 1'b1;
        capture(19, 3);
        for (int i = 0; i < 19; i++) begin
            s = slot_of(i);
            exp_v = {i < 14, s >= 0, i == 13, (s >= 0) ? exp_pix[s] : 8'h00};
            act_v = {tr_vs[i], tr_hr[i], tr_fd[i], tr_d[i]};
            n_checks++;
            if (act_v !== exp_v)
                $display("FAIL underflow_trace[%0d]: got {vs,href,fd,data}=%h, required %h", i, act_v, exp_v);
            else n_pass++;
        end
        n_checks++;
        if ({underflow, eol_err} !== 2'b10)
            $display("FAIL underflow_flags: got uf=%b eol=%b, required 1 0", underflow, eol_err);
        else n_pass++;
    endtask

    // tlast on column 2 of line 0 with width 4.
    task automatic test_eol_err();
        logic [DW+2:0] exp_v, act_v;
        int s;
        do_reset();
        set_geometry();
        for (int p = 0; p < 8; p++) begin
            exp_pix[p] = 8'hC0 + 8'(p);
            push_beat(exp_pix[p], p == 0, (p == 2) || (p == 7));
        end
        enable = 1'b1;
        capture(19, 3);
        for (int i = 0; i < 19; i++) begin
            s = slot_of(i);
            exp_v = {i < 14, s >= 0, i == 13, (s >= 0) ? exp_pix[s] : 8'h00};
            act_v = {tr_vs[i], tr_hr[i], tr_fd[i], tr_d[i]};
            n_checks++;
            if (act_v !== exp_v)
                $display("FAIL eol_trace[%0d]: got {vs,href,fd,data}=%h, required %h", i, act_v, exp_v);
            else n_pass++;
        end
        n_checks++;
        if ({underflow, eol_err} !== 2'b01)
            $display("FAIL eol_flags: got uf=%b eol=%b, required 0 1", underflow, eol_err);
        else n_pass++;
    endtask

    // enable dropped in line 0: frame completes, 5 cycles of VBLANK, then IDLE.
    task automatic test_enable_stop();
        int fd_count;
        int vs_high;
        do_reset();
        set_geometry();
        for (int p = 0; p < 8; p++) push_beat(8'h70 + 8'(p), p == 0, (p % 4) == 3);
        enable = 1'b1;
        capture(14, 3);
        fd_count = 0;
        for (int i = 0; i < 14; i++) if (tr_fd[i] === 1'b1) fd_count++;
        n_checks++;
        if (fd_count != 1)
            $display("FAIL stop_frame_done: got %0d pulses, required 1", fd_count);
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if (fsm_state !== ST_VBLANK)
            $display("FAIL stop_vblank: got state %0d, required %0d", fsm_state, ST_VBLANK);
        else n_pass++;
        tick();
        n_checks++;
        if (fsm_state !== ST_IDLE)
            $display("FAIL stop_idle: got state %0d, required %0d", fsm_state, ST_IDLE);
        else n_pass++;
        vs_high = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cmos_vsync !== 1'b0 || fsm_state !== ST_IDLE) vs_high++;
        end
        n_checks++;
        if (vs_high != 0)
            $display("FAIL stop_hold_low: got %0d cycles with vsync high or not idle, required 0", vs_high);
        else n_pass++;
    endtask

    // Reset in the middle of line 0: outputs and tready drop on the next cycle.
    task automatic test_reset_midline();
        int budget;
        do_reset();
        set_geometry();
        for (int p = 0; p < 8; p++) push_beat(8'h90 + 8'(p), p == 0, (p % 4) == 3);
        enable = 1'b1;
        budget = 0;
        while (cmos_href !== 1'b1 && budget < 100) begin
            tick();
            budget++;
        end
        n_checks++;
        if (cmos_href !== 1'b1)
            $display("FAIL midline_wait: href=%b after %0d cycles, required 1", cmos_href, budget);
        else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++;
        if ({cmos_vsync, cmos_href, cmos_data, axis.s_axis_tready} !== '0)
            $display("FAIL midline_reset: got vs=%b href=%b data=%h tready=%b, required all 0",
                     cmos_vsync, cmos_href, cmos_data, axis.s_axis_tready);
        else n_pass++;
        n_checks++;
        if (fsm_state !== ST_IDLE)
            $display("FAIL midline_state: got %0d, required %0d", fsm_state, ST_IDLE);
        else n_pass++;
        enable = 1'b0;
        reset  = 1'b0;
        tick();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset               = 1'b1;
        enable              = 1'b0;
        img_width           = '0;
        img_height          = '0;
        hblank              = '0;
        vblank              = '0;
        axis.s_axis_tvalid  = 1'b0;
        axis.s_axis_tdata   = '0;
        axis.s_axis_tuser   = 1'b0;
        axis.s_axis_tlast   = 1'b0;

        test_reset();
        test_basic_frame();
        test_junk_sof();
        test_underflow();
        test_eol_err();
        test_enable_stop();
        test_reset_midline();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
